clock_div_prog: RTL and testbench
=================================

Name: clock_div_prog

Overview:
- Runtime-programmable clock divider. Generates a divided clock-like signal `clk_div` from `clk`, plus single-cycle rise and fall strobes that downstream logic uses as clock enables.
- The period and the high time are loaded through a valid/ready config handshake. A new setting takes effect only at a period boundary, so the output never glitches.
- Used by display and graphics timing logic that needs more than one fixed pixel-rate ratio.

Parameters:
- CNT_W, 8, width of the period counter and of the config fields.
- DEFAULT_DIV, 5, period in clk cycles after reset. Legal range 2..2^CNT_W-1.
- DEFAULT_HIGH, 2, high cycles per period after reset. Legal range 1..DEFAULT_DIV-1.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- en  in  1  run enable.
- cfg_valid  in  1  config request.
- cfg_div  in  CNT_W  requested period.
- cfg_high  in  CNT_W  requested high time.
- cfg_ready  out  1  config slot free.
- cfg_done  out  1  pulse: pending config became active.
- cfg_err  out  1  pulse: accepted config rejected as illegal.
- clk_div  out  1  divided output, registered.
- tick_rise  out  1  pulse on the edge where clk_div goes 0->1.
- tick_fall  out  1  pulse on the edge where clk_div goes 1->0.

Behaviour:
- Single clock domain. All outputs are registered. Reset is synchronous, active-high.
- Reset state:
  - cnt = DEFAULT_DIV-1; div_r = DEFAULT_DIV; high_r = DEFAULT_HIGH.
  - Pending flag cleared; shadow registers cleared.
  - clk_div = 0; tick_rise, tick_fall, cfg_done, cfg_err = 0; cfg_ready = 1.
- Counting, on each edge with en=1:
  - cnt_next = (cnt == div_r-1) ? 0 : cnt+1.
  - clk_div <= (cnt_next < high_act). high_act is the high time in force for the period being entered.
  - The first enabled edge after reset or after re-enable wraps cnt to 0, so clk_div goes high on that edge.
- Steady state: clk_div is high for exactly high_r cycles, then low for div_r-high_r cycles, repeating.
- Strobes:
  - tick_rise <= !clk_div & clk_div_next; tick_fall <= clk_div & !clk_div_next.
  - Each pulses for exactly one cycle, aligned with the clk_div transition.
  - They track every transition, including the forced fall caused by disable.
- Config acceptance (handshake):
  - A transfer occurs when cfg_valid & cfg_ready at an edge.
  - Legality check: cfg_div >= 2 and 1 <= cfg_high < cfg_div.
  - Legal request: capture into shadow registers, set pending, cfg_ready <= 0.
  - Illegal request: cfg_err <= 1 for one cycle. No change to shadow or pending, and cfg_ready stays 1.
- Apply, with en=1 (boundary apply):
  - On the edge where cnt == div_r-1 and pending=1: div_r and high_r load from shadow, and high_act = shadow high for computing clk_div.
  - On that same edge, pending clears, cfg_done pulses, and cfg_ready <= 1.
- Apply, with en=0 (immediate apply):
  - A pending config applies on the next edge, with cnt forced to shadow div-1.
  - cfg_done pulses on that edge.
- Simultaneous accept and wrap: the config captured on a wrap edge is not applied on that edge; it applies at the next wrap. The period already in progress always completes with the old values.
- Disable, en=0:
  - cnt is forced to div_r-1 and clk_div <= 0; tick_fall pulses if clk_div was 1.
  - No tick_rise is generated.
  - Config acceptance continues to operate.
- Reset mid-operation: returns to the reset state on the next edge. Any pending config is discarded and no cfg_done is issued for it.
- Bench assertions:
  - cfg_ready=0 whenever pending=1.
  - tick_rise & tick_fall is never 1 in the same cycle.
  - With constant settings, the interval between consecutive tick_rise pulses equals div_r.

Test Plan:
- Default run: rst for 2 cycles, then en=1 -> clk_div repeats 1,1,0,0,0 from the first enabled edge; tick_rise every 5 cycles; tick_fall 2 cycles after each tick_rise.
- Reconfig mid-period: on cycle 2 of a period, cfg_div=8, cfg_high=3 -> accepted, cfg_ready=0; the current period finishes at 5 cycles; cfg_done pulses on the wrap edge; the pattern becomes 3 high / 5 low; cfg_ready=1 afterwards.
- Illegal configs: cfg_div=1; cfg_high=0; cfg_high=cfg_div=4 -> each gives one cfg_err pulse, cfg_ready stays 1, and the 5/2 pattern is undisturbed.
- Disable while high: en=0 on the first high cycle -> clk_div=0 next edge with one tick_fall. Re-enable -> clk_div=1 on the first edge with tick_rise, then a full 2-high/3-low period.
- Config while disabled: en=0, load 6/1 -> cfg_done on the next edge. Then en=1 -> pattern 1,0,0,0,0,0.
- Reset mid-pending: accept 8/3, assert rst before the wrap -> no cfg_done; after reset the pattern is 5/2. Corner case: CNT_W=8 with 255/254 -> 254 high, 1 low, no counter overflow.

Source files
------------

// File: rtl/clock_div_prog.sv
// rtl/clock_div_prog.sv - runtime-programmable clock divider with rise/fall strobes
module clock_div_prog #(
    parameter int CNT_W        = 8,
    parameter int DEFAULT_DIV  = 5,
    parameter int DEFAULT_HIGH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             cfg_valid,
    input  logic [CNT_W-1:0] cfg_div,
    input  logic [CNT_W-1:0] cfg_high,
    output logic             cfg_ready,
    output logic             cfg_done,
    output logic             cfg_err,
    output logic             clk_div,
    output logic             tick_rise,
    output logic             tick_fall
);

    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO      = CNT_W'(2);
    localparam logic [CNT_W-1:0] DEF_DIV  = CNT_W'(DEFAULT_DIV);
    localparam logic [CNT_W-1:0] DEF_HIGH = CNT_W'(DEFAULT_HIGH);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] div_r;
    logic [CNT_W-1:0] high_r;
    logic [CNT_W-1:0] sh_div;
    logic [CNT_W-1:0] sh_high;
    logic             pend;

    logic [CNT_W-1:0] cnt_next;
    logic [CNT_W-1:0] div_next;
    logic [CNT_W-1:0] high_next;
    logic [CNT_W-1:0] high_act;
    logic             clk_div_next;
    logic             wrap;
    logic             apply;
    logic             accept;
    logic             legal;

    // Next-count, config-apply and divided-output decode for the coming edge
    always_comb begin
        wrap         = (cnt == div_r - ONE);
        accept       = cfg_valid & cfg_ready;
        legal        = (cfg_div >= TWO) && (cfg_high != '0) && (cfg_high < cfg_div);
        apply        = 1'b0;
        div_next     = div_r;
        high_next    = high_r;
        cnt_next     = cnt;
        high_act     = high_r;
        clk_div_next = 1'b0;
        if (en) begin
            // A pending setting only lands on the wrap edge, so the period in
            // progress always finishes with the old values.
            apply    = wrap & pend;
            cnt_next = wrap ? '0 : cnt + ONE;
            if (apply) begin
                div_next  = sh_div;
                high_next = sh_high;
            end
            high_act     = high_next;
            clk_div_next = (cnt_next < high_act);
        end else begin
            // Output is parked low, so a pending setting can apply right away.
            // Parking cnt at div-1 makes the first enabled edge a wrap.
            apply = pend;
            if (pend) begin
                div_next  = sh_div;
                high_next = sh_high;
            end
            cnt_next = div_next - ONE;
        end
    end

    // State, strobes and config handshake registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= DEF_DIV - ONE;
            div_r     <= DEF_DIV;
            high_r    <= DEF_HIGH;
            sh_div    <= '0;
            sh_high   <= '0;
            pend      <= 1'b0;
            clk_div   <= 1'b0;
            tick_rise <= 1'b0;
            tick_fall <= 1'b0;
            cfg_done  <= 1'b0;
            cfg_err   <= 1'b0;
            cfg_ready <= 1'b1;
        end else begin
            cnt       <= cnt_next;
            div_r     <= div_next;
            high_r    <= high_next;
            clk_div   <= clk_div_next;
            tick_rise <= ~clk_div & clk_div_next;
            tick_fall <= clk_div & ~clk_div_next;
            cfg_done  <= apply;
            cfg_err   <= accept & ~legal;
            // Accept needs ready=1, which implies nothing pending, so it never
            // coincides with an apply of an older setting.
            if (accept && legal) begin
                sh_div    <= cfg_div;
                sh_high   <= cfg_high;
                pend      <= 1'b1;
                cfg_ready <= 1'b0;
            end else if (apply) begin
                pend      <= 1'b0;
                cfg_ready <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_clock_div_prog.sv
// tb/tb_clock_div_prog.sv - directed self-checking bench for clock_div_prog
module tb_clock_div_prog;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       cfg_valid = 1'b0;
    logic [7:0] cfg_div = '0;
    logic [7:0] cfg_high = '0;
    logic       cfg_ready;
    logic       cfg_done;
    logic       cfg_err;
    logic       clk_div;
    logic       tick_rise;
    logic       tick_fall;

    int checks = 0;
    int errors = 0;

    clock_div_prog #(.CNT_W(8), .DEFAULT_DIV(5), .DEFAULT_HIGH(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .cfg_valid (cfg_valid),
        .cfg_div   (cfg_div),
        .cfg_high  (cfg_high),
        .cfg_ready (cfg_ready),
        .cfg_done  (cfg_done),
        .cfg_err   (cfg_err),
        .clk_div   (clk_div),
        .tick_rise (tick_rise),
        .tick_fall (tick_fall)
    );

    always #5 clk = ~clk;

    // Rise and fall strobes must never coincide
    always @(negedge clk) begin
        checks++;
        if ((tick_rise === 1'b1) && (tick_fall === 1'b1)) begin
            errors++;
            $display("FAIL tick_excl: rise=%0b fall=%0b required not both 1", tick_rise, tick_fall);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        en = 1'b0;
        cfg_valid = 1'b0;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({clk_div, tick_rise, tick_fall, cfg_done, cfg_err, cfg_ready} !== 6'b000001) begin
            errors++;
            $display("FAIL reset_state: got %b required 000001",
                     {clk_div, tick_rise, tick_fall, cfg_done, cfg_err, cfg_ready});
        end
    endtask

    task automatic test_default();
        logic [2:0] exp;
        en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc();
            exp = {((i % 5) < 2), ((i % 5) == 0), ((i % 5) == 2)};
            checks++;
            if ({clk_div, tick_rise, tick_fall} !== exp) begin
                errors++;
                $display("FAIL default_run[%0d]: got %b required %b", i, {clk_div, tick_rise, tick_fall}, exp);
            end
        end
    endtask

    // Continues from test_default: counter sits at 4, next edge is cnt 0
    task automatic test_reconfig();
        logic [2:0] exp;
        cyc();
        cyc();
        cfg_valid = 1'b1;
        cfg_div = 8'd8;
        cfg_high = 8'd3;
        cyc();
        cfg_valid = 1'b0;
        checks++;
        if ({cfg_ready, clk_div, tick_fall} !== 3'b001) begin
            errors++;
            $display("FAIL reconfig_accept: ready/clk/fall got %b required 001", {cfg_ready, clk_div, tick_fall});
        end
        for (int i = 0; i < 2; i++) begin
            cyc();
            checks++;
            if ({cfg_done, clk_div, cfg_ready} !== 3'b000) begin
                errors++;
                $display("FAIL reconfig_old_tail[%0d]: got %b required 000", i, {cfg_done, clk_div, cfg_ready});
            end
        end
        for (int i = 0; i < 16; i++) begin
            cyc();
            exp = {((i % 8) < 3), ((i % 8) == 0), ((i % 8) == 3)};
            checks++;
            if ({clk_div, tick_rise, tick_fall} !== exp) begin
                errors++;
                $display("FAIL reconfig_run[%0d]: got %b required %b", i, {clk_div, tick_rise, tick_fall}, exp);
            end
            checks++;
            if ({cfg_done, cfg_ready} !== {(i == 0), 1'b1}) begin
                errors++;
                $display("FAIL reconfig_done[%0d]: done/ready got %b required %b", i, {cfg_done, cfg_ready}, {(i == 0), 1'b1});
            end
        end
    endtask

    task automatic test_illegal();
        logic [7:0] ill_div [3];
        logic [7:0] ill_high [3];
        logic       bad;
        int         k;
        ill_div  = '{8'd1, 8'd5, 8'd4};
        ill_high = '{8'd0, 8'd0, 8'd4};
        do_reset();
        en = 1'b1;
        for (int i = 0; i < 15; i++) begin
            bad = (i == 1) || (i == 6) || (i == 11);
            k = i / 5;
            cfg_valid = bad;
            cfg_div = ill_div[k];
            cfg_high = ill_high[k];
            cyc();
            cfg_valid = 1'b0;
            checks++;
            if ({clk_div, cfg_err, cfg_ready, cfg_done} !== {((i % 5) < 2), bad, 1'b1, 1'b0}) begin
                errors++;
                $display("FAIL illegal[%0d]: clk/err/ready/done got %b required %b", i,
                         {clk_div, cfg_err, cfg_ready, cfg_done}, {((i % 5) < 2), bad, 1'b1, 1'b0});
            end
        end
    endtask

    task automatic test_disable();
        logic [2:0] exp;
        do_reset();
        en = 1'b1;
        cyc();
        en = 1'b0;
        cyc();
        checks++;
        if ({clk_div, tick_rise, tick_fall} !== 3'b001) begin
            errors++;
            $display("FAIL disable_fall: got %b required 001", {clk_div, tick_rise, tick_fall});
        end
        cyc();
        checks++;
        if ({clk_div, tick_rise, tick_fall} !== 3'b000) begin
            errors++;
            $display("FAIL disable_idle: got %b required 000", {clk_div, tick_rise, tick_fall});
        end
        en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            exp = {(i < 2), (i == 0), (i == 2)};
            checks++;
            if ({clk_div, tick_rise, tick_fall} !== exp) begin
                errors++;
                $display("FAIL reenable[%0d]: got %b required %b", i, {clk_div, tick_rise, tick_fall}, exp);
            end
        end
    endtask

    task automatic test_cfg_disabled();
        logic [2:0] exp;
        do_reset();
        cfg_valid = 1'b1;
        cfg_div = 8'd6;
        cfg_high = 8'd1;
        cyc();
        cfg_valid = 1'b0;
        checks++;
        if ({cfg_ready, cfg_done} !== 2'b00) begin
            errors++;
            $display("FAIL dis_accept: ready/done got %b required 00", {cfg_ready, cfg_done});
        end
        cyc();
        checks++;
        if ({cfg_ready, cfg_done, clk_div} !== 3'b110) begin
            errors++;
            $display("FAIL dis_apply: ready/done/clk got %b required 110", {cfg_ready, cfg_done, clk_div});
        end
        en = 1'b1;
        for (int i = 0; i < 12; i++) begin
            cyc();
            exp = {((i % 6) == 0), ((i % 6) == 0), ((i % 6) == 1)};
            checks++;
            if ({clk_div, tick_rise, tick_fall} !== exp) begin
                errors++;
                $display("FAIL dis_run[%0d]: got %b required %b", i, {clk_div, tick_rise, tick_fall}, exp);
            end
        end
    endtask

    task automatic test_reset_pending();
        do_reset();
        en = 1'b1;
        cyc();
        cfg_valid = 1'b1;
        cfg_div = 8'd8;
        cfg_high = 8'd3;
        cyc();
        cfg_valid = 1'b0;
        checks++;
        if (cfg_ready !== 1'b0) begin
            errors++;
            $display("FAIL rstpend_accept: ready got %b required 0", cfg_ready);
        end
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        checks++;
        if ({clk_div, cfg_ready, cfg_done} !== 3'b010) begin
            errors++;
            $display("FAIL rstpend_reset: clk/ready/done got %b required 010", {clk_div, cfg_ready, cfg_done});
        end
        for (int i = 0; i < 10; i++) begin
            cyc();
            checks++;
            if ({clk_div, cfg_done} !== {((i % 5) < 2), 1'b0}) begin
                errors++;
                $display("FAIL rstpend_run[%0d]: clk/done got %b required %b", i, {clk_div, cfg_done}, {((i % 5) < 2), 1'b0});
            end
        end
    endtask

    task automatic test_corner();
        logic [2:0] exp;
        do_reset();
        cfg_valid = 1'b1;
        cfg_div = 8'd255;
        cfg_high = 8'd254;
        cyc();
        cfg_valid = 1'b0;
        cyc();
        checks++;
        if (cfg_done !== 1'b1) begin
            errors++;
            $display("FAIL corner_apply: done got %b required 1", cfg_done);
        end
        en = 1'b1;
        for (int i = 0; i < 510; i++) begin
            cyc();
            exp = {((i % 255) < 254), ((i % 255) == 0), ((i % 255) == 254)};
            checks++;
            if ({clk_div, tick_rise, tick_fall} !== exp) begin
                errors++;
                $display("FAIL corner_run[%0d]: got %b required %b", i, {clk_div, tick_rise, tick_fall}, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_default();
        test_reconfig();
        test_illegal();
        test_disable();
        test_cfg_disabled();
        test_reset_pending();
        test_corner();
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
